// File: rtl/bram_fill_drain_sched.sv
// Fill/drain scheduler: bytes go from external memory into broadcast BRAMs on port A, then words drain on port B under ready/valid backpressure.
// Optional stall counter is built only when STALL_CNT_EN is defined.
module bram_fill_drain_sched #(
    parameter int LOAD_DEPTH = 2048,
    parameter int MEM_AW     = 18,
    parameter int SEL_W      = 2
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        block_count,
    input  logic              out_ready,
    output logic              busy,
    output logic              complete,
    output logic [MEM_AW-1:0] mem_address,
    output logic [10:0]       addr_a,
    output logic              en_a,
    output logic              we_a,
    output logic [8:0]        addr_b,
    output logic              en_b,
    output logic              sm_en,
    output logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    output logic              stall,
    output logic [15:0]       stall_cycles
);

    localparam int          READ_DEPTH = LOAD_DEPTH / 4;
    localparam logic [10:0] LAST_A     = 11'(LOAD_DEPTH - 1);
    localparam logic [9:0]  READ_WORDS = 10'(READ_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        blocks_left_q, blocks_left_d;
    logic [MEM_AW-1:0] mem_address_q, mem_address_d;
    logic [10:0]       addr_a_q, addr_a_d;
    logic [8:0]        addr_b_q, addr_b_d;
    logic [9:0]        words_left_q, words_left_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    logic              accept;
    logic              issue;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            blocks_left_q <= '0;
            mem_address_q <= '0;
            addr_a_q      <= '0;
            addr_b_q      <= '0;
            words_left_q  <= '0;
            sel_q         <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            blocks_left_q <= blocks_left_d;
            mem_address_q <= mem_address_d;
            addr_a_q      <= addr_a_d;
            addr_b_q      <= addr_b_d;
            words_left_q  <= words_left_d;
            sel_q         <= sel_d;
            out_valid_q   <= out_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        blocks_left_d = blocks_left_q;
        mem_address_d = mem_address_q;
        addr_a_d      = addr_a_q;
        addr_b_d      = addr_b_q;
        words_left_d  = words_left_q;
        sel_d         = sel_q;
        out_valid_d   = out_valid_q;
        en_a          = 1'b0;
        we_a          = 1'b0;
        en_b          = 1'b0;
        issue         = 1'b0;
        accept        = out_valid_q & out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    blocks_left_d = block_count;
                    addr_a_d      = '0;
                    state_d       = (block_count == 8'd0) ? DONE : FILL;
                end
            end
            FILL: begin
                en_a          = 1'b1;
                we_a          = 1'b1;
                mem_address_d = mem_address_q + MEM_AW'(1);
                if (addr_a_q == LAST_A) begin
                    addr_a_d     = '0;
                    addr_b_d     = '0;
                    words_left_d = READ_WORDS;
                    sel_d        = '0;
                    state_d      = DRAIN;
                end else begin
                    addr_a_d = addr_a_q + 11'd1;
                end
            end
            DRAIN: begin
                // A read may only issue when the output register is free or is being emptied this cycle.
                issue = (words_left_q != 10'd0) && (!out_valid_q || out_ready);
                en_b  = issue;
                if (issue) begin
                    words_left_d = words_left_q - 10'd1;
                    if (words_left_q != 10'd1) begin
                        addr_b_d = addr_b_q + 9'd1;
                    end
                    out_valid_d = 1'b1;
                end else if (accept) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    sel_d = sel_q + SEL_W'(1);
                end
                if (accept && (words_left_q == 10'd0)) begin
                    blocks_left_d = blocks_left_q - 8'd1;
                    state_d       = (blocks_left_q == 8'd1) ? DONE : FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign complete    = (state_q == DONE);
    assign mem_address = mem_address_q;
    assign addr_a      = addr_a_q;
    assign addr_b      = addr_b_q;
    assign sel         = sel_q;
    assign out_valid   = out_valid_q;
    assign sm_en       = out_valid_q;
    assign stall       = out_valid_q & ~out_ready;

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Cleared by any accepted start, including a zero-block job.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_bram_fill_drain_sched.sv
// Directed bench for bram_fill_drain_sched with LOAD_DEPTH=16 and a behavioural external memory / BRAM model.
module tb_bram_fill_drain_sched;

    localparam int LD = 16;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  block_count = 8'd0;
    logic        out_ready = 1'b0;
    logic        busy, complete, en_a, we_a, en_b, sm_en, out_valid, stall;
    logic [17:0] mem_address;
    logic [10:0] addr_a;
    logic [8:0]  addr_b;
    logic [1:0]  sel;
    logic [15:0] stall_cycles;

    int errCount = 0;
    int checkCount = 0;
    int memBase = 0;
    int fillCnt, issueCnt, beatCnt, completeCnt, completeAt, overlapCnt, validSeen, stallSeen;

    logic [7:0]  bram [0:2047];
    logic [31:0] dout;

    bram_fill_drain_sched #(.LOAD_DEPTH(LD), .MEM_AW(18), .SEL_W(2)) dut (
        .CLK(CLK), .rst(rst), .start(start), .block_count(block_count),
        .out_ready(out_ready), .busy(busy), .complete(complete),
        .mem_address(mem_address), .addr_a(addr_a), .en_a(en_a), .we_a(we_a),
        .addr_b(addr_b), .en_b(en_b), .sm_en(sm_en), .sel(sel),
        .out_valid(out_valid), .stall(stall), .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    // External memory returns byte[i] = i; BRAM has one cycle of read latency.
    always @(posedge CLK) begin
        if (en_a && we_a) bram[addr_a] <= mem_address[7:0];
        if (en_b) dout <= {bram[{addr_b, 2'd3}], bram[{addr_b, 2'd2}], bram[{addr_b, 2'd1}], bram[{addr_b, 2'd0}]};
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] expWord(input int b);
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({busy, complete, en_a, we_a, en_b, sm_en, out_valid, stall, sel}), 32'd0);
        checkOutput({tag, "_addr"}, 32'({addr_a, addr_b}), 32'd0);
        checkOutput({tag, "_mem"}, 32'(mem_address), 32'd0);
        checkOutput({tag, "_stallcnt"}, 32'(stall_cycles), 32'd0);
    endtask

    task automatic resetDut();
        @(negedge CLK);
        rst = 1'b0;
        #1;
        checkResetOutputs("reset");
        @(negedge CLK);
        rst = 1'b1;
        memBase = 0;
    endtask

    // Runs one job; restartAt/resetAt/stallBeat < 0 disable that disturbance.
    task automatic applyStimulus(input int blocks, input int stallBeat, input int stallLen,
                                 input int restartAt, input int resetAt, input int maxCycles);
        int stallCtr;
        logic [31:0] holdData;
        logic [8:0]  holdAddr;
        logic [1:0]  holdSel;
        stallCtr = 0; holdData = '0; holdAddr = '0; holdSel = '0;
        fillCnt = 0; issueCnt = 0; beatCnt = 0; completeCnt = 0;
        completeAt = -1; overlapCnt = 0; validSeen = 0; stallSeen = 0;
        @(negedge CLK);
        start = 1'b1;
        block_count = 8'(blocks);
        out_ready = 1'b1;
        @(posedge CLK);
        for (int k = 0; k < maxCycles; k++) begin
            @(negedge CLK);
            start = (k == restartAt);
            block_count = 8'hA5;
            out_ready = 1'b1;
            if (out_valid && beatCnt == stallBeat && stallCtr < stallLen) begin
                out_ready = 1'b0;
                stallCtr++;
            end
            if (k == resetAt) rst = 1'b0;
            #1;
            if (k == resetAt) begin
                checkResetOutputs("midrst");
                @(negedge CLK);
                rst = 1'b1;
                break;
            end
            if (en_a) begin
                checkOutput("fill_we", 32'(we_a), 32'd1);
                checkOutput("fill_addr_a", 32'(addr_a), 32'(fillCnt % LD));
                checkOutput("fill_mem", 32'(mem_address), 32'((memBase + fillCnt) % 262144));
                fillCnt++;
            end
            if (en_a && en_b) overlapCnt++;
            if (en_b) begin
                checkOutput("rd_addr_b", 32'(addr_b), 32'(issueCnt % (LD / 4)));
                issueCnt++;
            end
            if (out_valid) begin
                validSeen++;
                checkOutput("sm_en", 32'(sm_en), 32'd1);
            end
            if (out_valid && !out_ready) begin
                stallSeen++;
                checkOutput("stall_flag", 32'(stall), 32'd1);
                checkOutput("stall_en_b", 32'(en_b), 32'd0);
                if (stallSeen == 1) begin
                    holdData = dout; holdAddr = addr_b; holdSel = sel;
                end else begin
                    checkOutput("stall_data", dout, holdData);
                    checkOutput("stall_addr_b", 32'(addr_b), 32'(holdAddr));
                    checkOutput("stall_sel", 32'(sel), 32'(holdSel));
                end
            end
            if (out_valid && out_ready) begin
                checkOutput("beat_sel", 32'(sel), 32'(beatCnt % 4));
                checkOutput("beat_data", dout, expWord(memBase + 4 * beatCnt));
                beatCnt++;
            end
            if (complete) begin
                completeCnt++;
                if (completeAt < 0) completeAt = k;
                checkOutput("busy_done", 32'(busy), 32'd1);
            end
            if (completeAt >= 0 && k == completeAt + 1) begin
                checkOutput("busy_idle", 32'(busy), 32'd0);
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (resetAt >= 0) memBase = 0;
        else memBase = memBase + LD * blocks;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #1;
        checkResetOutputs("por");
        @(negedge CLK);
        rst = 1'b1;

        $display("[TB] single block, ready held high");
        applyStimulus(1, -1, 0, -1, -1, 40);
        checkOutput("t1_fill", 32'(fillCnt), 32'd16);
        checkOutput("t1_issues", 32'(issueCnt), 32'd4);
        checkOutput("t1_beats", 32'(beatCnt), 32'd4);
        checkOutput("t1_complete_at", 32'(completeAt), 32'd21);
        checkOutput("t1_complete_cnt", 32'(completeCnt), 32'd1);
        checkOutput("t1_overlap", 32'(overlapCnt), 32'd0);

        $display("[TB] three blocks from a fresh reset");
        resetDut();
        applyStimulus(3, -1, 0, -1, -1, 100);
        checkOutput("t2_fill", 32'(fillCnt), 32'd48);
        checkOutput("t2_beats", 32'(beatCnt), 32'd12);
        checkOutput("t2_complete_at", 32'(completeAt), 32'd63);
        checkOutput("t2_complete_cnt", 32'(completeCnt), 32'd1);
        checkOutput("t2_overlap", 32'(overlapCnt), 32'd0);

        $display("[TB] backpressure on beat 2 for 5 cycles");
        applyStimulus(1, 2, 5, -1, -1, 60);
        checkOutput("t3_stall_seen", 32'(stallSeen), 32'd5);
        checkOutput("t3_beats", 32'(beatCnt), 32'd4);
        checkOutput("t3_issues", 32'(issueCnt), 32'd4);
        checkOutput("t3_complete_at", 32'(completeAt), 32'd26);
`ifdef STALL_CNT_EN
        checkOutput("t3_stall_cycles", 32'(stall_cycles), 32'd5);
`else
        checkOutput("t3_stall_cycles", 32'(stall_cycles), 32'd0);
`endif

        $display("[TB] zero block job");
        applyStimulus(0, -1, 0, -1, -1, 10);
        checkOutput("t4_complete_at", 32'(completeAt), 32'd0);
        checkOutput("t4_complete_cnt", 32'(completeCnt), 32'd1);
        checkOutput("t4_fill", 32'(fillCnt), 32'd0);
        checkOutput("t4_issues", 32'(issueCnt), 32'd0);
        checkOutput("t4_valid", 32'(validSeen), 32'd0);
        checkOutput("t4_stall_cycles", 32'(stall_cycles), 32'd0);

        $display("[TB] reset during drain beat 1");
        applyStimulus(1, -1, 0, -1, 18, 40);
        checkOutput("t5_complete_cnt", 32'(completeCnt), 32'd0);
        checkOutput("t5_beats", 32'(beatCnt), 32'd1);
        applyStimulus(1, -1, 0, -1, -1, 40);
        checkOutput("t5b_fill", 32'(fillCnt), 32'd16);
        checkOutput("t5b_beats", 32'(beatCnt), 32'd4);
        checkOutput("t5b_complete_at", 32'(completeAt), 32'd21);

        $display("[TB] start pulsed again mid-fill");
        applyStimulus(1, -1, 0, 5, -1, 40);
        checkOutput("t6_fill", 32'(fillCnt), 32'd16);
        checkOutput("t6_beats", 32'(beatCnt), 32'd4);
        checkOutput("t6_complete_at", 32'(completeAt), 32'd21);
        checkOutput("t6_complete_cnt", 32'(completeCnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bram_fill_drain_sched.md
Name: bram_fill_drain_sched

Overview:
Sequencing controller for the external-memory → BRAM → steer-module datapath. For each block it fills all broadcast BRAMs through port A, one byte per cycle, from the external memory. It then drains them through port B, one 32-bit word per issued read, into the steer modules. Drain honours a downstream ready/valid handshake and repeats for a programmable number of blocks. It replaces the free-running control/address pair with a single backpressure-aware scheduler.

Parameters:
LOAD_DEPTH, 2048, bytes written per BRAM per block; power of 2, 8..2048; READ_DEPTH = LOAD_DEPTH/4 words.
MEM_AW, 18, external memory address width.
SEL_W, 2, steer select width.

Ports:
CLK  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous active-low reset.
start  in  1  1-cycle request; sampled only in IDLE.
block_count  in  8  number of blocks to process; latched on accepted start.
out_ready  in  1  downstream accepts the current steer beat.
busy  out  1  high in any state other than IDLE.
complete  out  1  1-cycle pulse when the job ends.
mem_address  out  MEM_AW  external memory read address.
addr_a  out  11  BRAM port-A byte address (broadcast).
en_a  out  1  port-A enable.
we_a  out  1  port-A write enable.
addr_b  out  9  BRAM port-B word address (broadcast).
en_b  out  1  port-B read enable.
sm_en  out  1  steer-module enable; equals out_valid.
sel  out  SEL_W  steer output select for the current beat.
out_valid  out  1  steer outputs hold a valid beat.
stall  out  1  out_valid & !out_ready.
stall_cycles  out  16  stall counter (optional feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE.
  - All outputs 0; mem_address base 0.
  - Counters cleared.
  - Reset mid-job aborts the job with no complete pulse.
- States:
  - IDLE → FILL on start when block_count≠0. block_count latched, mem_address keeps its running base (0 after reset).
  - IDLE → DONE on start when block_count=0. No BRAM access occurs.
  - FILL: en_a=we_a=1 every cycle. addr_a steps 0..LOAD_DEPTH-1. mem_address increments by 1 per cycle, combinational memory data is written the same cycle. Lasts exactly LOAD_DEPTH cycles, then DRAIN.
  - DRAIN: a read issues (en_b=1) when words_left≠0 and (!out_valid | out_ready).
    - addr_b steps 0..READ_DEPTH-1, one per issued read.
    - BRAM latency is 1 cycle: out_valid rises the cycle after issue.
    - out_valid clears on the handshake out_valid&out_ready unless a new read issues the same cycle.
    - When out_ready=0 with out_valid=1: en_b=0, addr_b and sel hold, BRAM output holds.
    - When the last word is accepted: if blocks remain → FILL (next block, mem_address continuing); else → DONE.
  - DONE: complete=1 for one cycle, busy=0 from the next cycle → IDLE.
- sel increments modulo 2^SEL_W on each accepted beat, so 4 consecutive words map to Out1..Out4. sel resets to 0 at the start of each block's DRAIN.
- mem_address wraps modulo 2^MEM_AW; no error is raised.
- start while busy is ignored. block_count changes after acceptance are ignored.
- en_a and en_b are never asserted in the same cycle.
- Throughput: with out_ready held at 1, DRAIN issues one read per cycle. One block takes LOAD_DEPTH + READ_DEPTH + 1 cycles.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined: stall_cycles counts cycles with stall=1, saturating at 16'hFFFF. It clears on an accepted start and on reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
1. LOAD_DEPTH=16, block_count=1, out_ready=1, memory byte[i]=i:
   - FILL writes addr_a 0..15 over 16 cycles.
   - DRAIN beats 32'h03020100..32'h0F0E0D0C appear on 4 consecutive cycles with sel=0,1,2,3.
   - complete pulses at cycle 21 after start.
2. block_count=3, LOAD_DEPTH=16:
   - mem_address runs 0..47 continuously across the three FILL phases.
   - Exactly 12 beats are accepted; exactly one complete pulse.
3. out_ready held low for 5 cycles on beat 2:
   - out_valid stays 1, addr_b/sel/data stable, en_b=0, stall=1 for 5 cycles.
   - No beat is lost or duplicated.
   - With STALL_CNT_EN defined, stall_cycles=5.
4. block_count=0:
   - complete pulses on the cycle after start.
   - en_a, en_b and out_valid never assert.
5. rst driven low during DRAIN beat 1:
   - All outputs are 0 immediately (asynchronous), no complete pulse.
   - A new start after reset is released begins at mem_address 0.
6. start pulsed again mid-FILL:
   - Ignored; addr_a sequence and beat count unchanged.
